// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event scheduler.
// Imported by the repeat timer and the scheduler top.
package button_event_pkg;

  typedef enum logic {
    SEL,
    OFFER
  } sched_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FIRST,
    R_REPEAT
  } rpt_phase_t;

  localparam logic EV_PRESS  = 1'b0;
  localparam logic EV_REPEAT = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_repeat_timer.sv
// Per-button hold/auto-repeat timer.
// Emits a one-cycle tick after the hold delay, then at every repeat period.
module btn_repeat_timer
  import button_event_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk_hifreq,
  input  logic rst,
  input  logic lvl,
  input  logic rise,
  output logic tick
);

  localparam int CW = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  rpt_phase_t    ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q + 1'b1;
    tick  = 1'b0;
    if (!lvl) begin
      ph_d  = R_IDLE;
      cnt_d = '0;
    end else if (rise) begin
      ph_d  = R_FIRST;
      cnt_d = '0;
    end else begin
      unique case (ph_q)
        R_FIRST: begin
          if (cnt_q == HOLD_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
            ph_d  = R_REPEAT;
          end
        end
        R_REPEAT: begin
          if (cnt_q == REP_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      ph_q  <= R_IDLE;
      cnt_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns button presses and auto-repeats into events, sharing one
// valid/ready consumer among all buttons with a round-robin arbiter.
module button_event_scheduler
  import button_event_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                       clk_hifreq,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_lvl,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic [$clog2(NUM_BTN)-1:0] event_id,
  output logic                       event_is_repeat,
  output logic [NUM_BTN-1:0]         overrun,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0] btn_q, rise, tick;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] pkind_q, pkind_d;
  logic [NUM_BTN-1:0] ovr_q, ovr_d;
  logic [NUM_BTN-1:0] grant;
  logic [IW-1:0]      rr_q, id_q, sel_idx;
  logic               rep_q, sel_found, load;
  sched_state_t       state_q, state_d;

  assign rise = btn_lvl & ~btn_q;

  if (REPEAT_EN != 0) begin : g_rpt
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_tmr
      btn_repeat_timer #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_tmr (
        .clk_hifreq(clk_hifreq),
        .rst       (rst),
        .lvl       (btn_lvl[i]),
        .rise      (rise[i]),
        .tick      (tick[i])
      );
    end
  end else begin : g_no_rpt
    assign tick = '0;
  end

  // A new event may refill a bit in the same cycle it is granted.
  always_comb begin
    pend_d  = pend_q;
    pkind_d = pkind_q;
    ovr_d   = ovr_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if ((rise[i] || tick[i]) && (grant[i] || !pend_q[i])) begin
        pend_d[i]  = 1'b1;
        pkind_d[i] = rise[i] ? EV_PRESS : EV_REPEAT;
      end else if (rise[i] || tick[i]) begin
        ovr_d[i] = 1'b1;
      end else if (grant[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin : p_arb
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_BTN) j = j - NUM_BTN;
      if (!sel_found && pend_q[j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = '0;
    load    = 1'b0;
    unique case (state_q)
      SEL: begin
        if (sel_found) begin
          grant[sel_idx] = 1'b1;
          load           = 1'b1;
          state_d        = OFFER;
        end
      end
      OFFER: begin
        if (event_ready) state_d = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      state_q <= SEL;
      rr_q    <= IW'(NUM_BTN - 1);
      id_q    <= '0;
      rep_q   <= EV_PRESS;
      pend_q  <= '0;
      pkind_q <= '0;
      ovr_q   <= '0;
      btn_q   <= btn_lvl;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pkind_q <= pkind_d;
      ovr_q   <= ovr_d;
      btn_q   <= btn_lvl;
      if (load) begin
        id_q  <= sel_idx;
        rep_q <= pkind_q[sel_idx];
        rr_q  <= sel_idx;
      end
    end
  end

  assign event_valid     = (state_q == OFFER);
  assign event_id        = id_q;
  assign event_is_repeat = rep_q;
  assign overrun         = ovr_q;
  assign busy            = (|pend_q) | event_valid;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler.
// Expected events are queued with their handshake cycle and checked on delivery.
module tb_button_event_scheduler;

  logic       clk_hifreq = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_lvl = '0;
  logic       event_valid;
  logic       event_ready = 1'b1;
  logic [1:0] event_id;
  logic       event_is_repeat;
  logic [3:0] overrun;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic       rep;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  button_event_scheduler #(
    .NUM_BTN      (4),
    .REPEAT_EN    (1),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk_hifreq     (clk_hifreq),
    .rst            (rst),
    .btn_lvl        (btn_lvl),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_id       (event_id),
    .event_is_repeat(event_is_repeat),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk_hifreq = ~clk_hifreq;

  always @(posedge clk_hifreq) cyc = cyc + 1;

  always @(negedge clk_hifreq) begin
    if (!rst && event_valid && event_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got id=%0d rep=%0d cyc=%0d required none",
                 event_id, event_is_repeat, cyc);
      end else begin
        e = exp_q.pop_front();
        if (event_id !== e.id || event_is_repeat !== e.rep || cyc !== e.cyc) begin
          failures++;
          $display("FAIL event got id=%0d rep=%0d cyc=%0d required id=%0d rep=%0d cyc=%0d",
                   event_id, event_is_repeat, cyc, e.id, e.rep, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_hifreq);
      #1;
    end
  endtask

  task automatic push(input int c, input int id, input bit rep);
    exp_t x;
    x.cyc = c;
    x.id  = 2'(id);
    x.rep = rep;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      step(1);
      n++;
    end
    step(12);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got remaining=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_lvl = '0;
    event_ready = 1'b1;
    step(3);
    checks++;
    if (event_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got %b required 0", event_valid);
    end
    checks++;
    if (event_id !== 2'd0 || event_is_repeat !== 1'b0) begin
      failures++;
      $display("FAIL rst_id got %0d/%b required 0/0", event_id, event_is_repeat);
    end
    checks++;
    if (overrun !== 4'b0000) begin
      failures++;
      $display("FAIL rst_overrun got %b required 0000", overrun);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (busy !== 1'b0 || event_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got %b/%b required 0/0", busy, event_valid);
    end
  endtask

  task automatic test_round_robin;
    int c;
    for (int b = 0; b < 2; b++) begin
      c = cyc;
      btn_lvl = 4'b1111;
      for (int k = 0; k < 4; k++) push(c + 2 + 2 * k, k, 1'b0);
      step(2);
      btn_lvl = '0;
      drain("round_robin");
    end
  endtask

  task automatic test_single_press;
    int c;
    c = cyc;
    btn_lvl = 4'b0001;
    push(c + 2, 0, 1'b0);
    step(2);
    btn_lvl = '0;
    drain("single_press");
    checks++;
    if (overrun !== 4'b0000) begin
      failures++;
      $display("FAIL single_overrun got %b required 0000", overrun);
    end
  endtask

  task automatic test_hold;
    int c;
    c = cyc;
    btn_lvl = 4'b0100;
    push(c + 2, 2, 1'b0);
    for (int k = 0; k < 6; k++) push(c + 10 + 4 * k, 2, 1'b1);
    step(30);
    btn_lvl = '0;
    drain("hold");
  endtask

  task automatic test_overrun;
    int c;
    event_ready = 1'b0;
    c = cyc;
    btn_lvl = 4'b0010;
    step(1);
    btn_lvl = '0;
    step(2);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 2'd1) begin
      failures++;
      $display("FAIL bp_offer got %b/%0d required 1/1", event_valid, event_id);
    end
    btn_lvl = 4'b0010;
    step(1);
    btn_lvl = '0;
    step(1);
    btn_lvl = 4'b0010;
    step(1);
    btn_lvl = '0;
    step(1);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 2'd1 || event_is_repeat !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got %b/%0d/%b required 1/1/0",
               event_valid, event_id, event_is_repeat);
    end
    checks++;
    if (overrun !== 4'b0010) begin
      failures++;
      $display("FAIL bp_overrun got %b required 0010", overrun);
    end
    push(c + 7, 1, 1'b0);
    push(c + 9, 1, 1'b0);
    event_ready = 1'b1;
    drain("backpressure");
    checks++;
    if (overrun !== 4'b0010) begin
      failures++;
      $display("FAIL bp_sticky got %b required 0010", overrun);
    end
  endtask

  task automatic test_reset_behaviour;
    int c;
    btn_lvl = 4'b1000;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    checks++;
    if (overrun !== 4'b0000 || event_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_rst got ovr=%b v=%b b=%b required 0000/0/0",
               overrun, event_valid, busy);
    end
    step(12);
    btn_lvl = '0;
    step(1);
    c = cyc;
    btn_lvl = 4'b1000;
    push(c + 2, 3, 1'b0);
    step(2);
    btn_lvl = '0;
    drain("repress");
    event_ready = 1'b0;
    btn_lvl = 4'b0101;
    step(1);
    btn_lvl = '0;
    step(1);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_offer got %b/%0d required 1/0", event_valid, event_id);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (event_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_offer got v=%b b=%b required 0/0", event_valid, busy);
    end
    rst = 1'b0;
    event_ready = 1'b1;
    drain("after_rst");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_press();
    test_hold();
    test_overrun();
    test_reset_behaviour();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
